// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the memory-access stage. It services load/store
// requests from a word-addressed backing RAM. A direct-mapped presence table
// (tags and valid bits only, no data) models hit/miss timing. A load miss
// stalls the pipeline for a fixed fill latency and then returns the data.
// Stores are write-through with no allocation and never stall.
//
// Ports:
//   Clk          in   rising-edge clock
//   Rst          in   synchronous reset, active high
//   i_req_valid  in   request present this cycle
//   i_req_we     in   1 = store, 0 = load
//   i_req_addr   in   byte address; bits [1:0] ignored, bits above RAM alias
//   i_req_be     in   store byte enables, bit n writes byte n
//   i_req_wdata  in   store data
//   o_rdata      out  load data (registered)
//   o_rvalid     out  one-cycle pulse qualifying o_rdata
//   o_miss       out  stall request (combinational from state and lookup)
//   o_busy       out  FSM not in IDLE
//   o_hit_cnt    out  saturating load-hit count  (only with DMEM_STATS_EN)
//   o_miss_cnt   out  saturating load-miss count (only with DMEM_STATS_EN)
//
// Optional feature macro: DMEM_STATS_EN adds the hit/miss statistic counters.
//
// Stall timing: the miss-detection cycle in IDLE counts as the first latency
// cycle, so the FSM spends MISS_LAT-1 cycles in MISS and one in FILL, giving
// a total load-miss stall of MISS_LAT+1 cycles. LINES must be at least 2.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int MEM_DEPTH = 1024,
    parameter int LINES     = 16,
    parameter int MISS_LAT  = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [3:0]  i_req_be,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_miss,
    output logic        o_busy
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] o_hit_cnt,
    output logic [15:0] o_miss_cnt
`endif
);

    localparam int WIDX_W = $clog2(MEM_DEPTH);
    localparam int LINE_W = $clog2(LINES);
    localparam int TAG_W  = (WIDX_W > LINE_W) ? (WIDX_W - LINE_W) : 1;
    localparam int CNT_W  = $clog2(MISS_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

    // Byte-lane merge used for partial stores.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Storage and state
    logic [31:0]       ram_r [MEM_DEPTH];
    logic [TAG_W-1:0]  tag_r [LINES];
    logic [LINES-1:0]  valid_r;
    state_t            state_r;
    state_t            state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [WIDX_W-1:0] lat_widx_r;

    // Request decode
    logic [WIDX_W-1:0] widx_s;
    logic [LINE_W-1:0] line_s;
    logic [TAG_W-1:0]  tag_s;
    logic              hit_s;
    logic              idle_s;
    logic              load_s;
    logic              store_s;
    logic              hit_accept_s;
    logic              miss_detect_s;
    logic              miss_s;

    // Latched request copy used during MISS/FILL
    logic [LINE_W-1:0] lat_line_s;
    logic [TAG_W-1:0]  lat_tag_s;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^{i_req_addr[1:0], i_req_addr[31:WIDX_W+2]};

    assign widx_s     = i_req_addr[2 +: WIDX_W];
    assign line_s     = widx_s[LINE_W-1:0];
    assign tag_s      = TAG_W'(widx_s >> LINE_W);
    assign lat_line_s = lat_widx_r[LINE_W-1:0];
    assign lat_tag_s  = TAG_W'(lat_widx_r >> LINE_W);

    assign hit_s         = valid_r[line_s] && (tag_r[line_s] == tag_s);
    assign idle_s        = (state_r == IDLE);
    assign load_s        = i_req_valid && !i_req_we;
    assign store_s       = i_req_valid && i_req_we;
    assign hit_accept_s  = idle_s && load_s && hit_s;
    assign miss_detect_s = idle_s && load_s && !hit_s;

    // Next-state and stall logic for the miss FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        miss_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (miss_detect_s) begin
                    miss_s     = 1'b1;
                    cnt_next_s = CNT_W'(MISS_LAT - 1);
                    // The detection cycle is the first latency cycle, so a
                    // single-cycle latency goes straight to FILL.
                    if (MISS_LAT == 1) begin
                        state_next_s = FILL;
                    end else begin
                        state_next_s = MISS;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            MISS: begin
                miss_s = 1'b1;
                if (cnt_r <= CNT_W'(1)) begin
                    state_next_s = FILL;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = MISS;
                    cnt_next_s   = cnt_r - CNT_W'(1);
                end
            end
            FILL: begin
                miss_s       = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                miss_s       = 1'b0;
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign o_miss = miss_s;
    assign o_busy = (state_r != IDLE);

    // FSM state, latency counter and latched miss address.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            lat_widx_r <= {WIDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (miss_detect_s) begin
                lat_widx_r <= widx_s;
            end
        end
    end

    // Backing RAM store port (not reset; stores only accepted in IDLE).
    always_ff @(posedge Clk) begin
        if (!Rst && idle_s && store_s) begin
            ram_r[widx_s] <= merge_bytes(ram_r[widx_s], i_req_wdata, i_req_be);
        end
    end

    // Presence table and registered load response.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_r  <= {LINES{1'b0}};
            o_rdata  <= 32'h0000_0000;
            o_rvalid <= 1'b0;
            for (int l = 0; l < LINES; l++) begin
                tag_r[l] <= {TAG_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (hit_accept_s) begin
                        o_rdata  <= ram_r[widx_s];
                        o_rvalid <= 1'b1;
                    end else begin
                        o_rvalid <= 1'b0;
                    end
                end
                FILL: begin
                    // Fill uses the address captured at miss detection,
                    // overwriting any conflicting tag in that line.
                    valid_r[lat_line_s] <= 1'b1;
                    tag_r[lat_line_s]   <= lat_tag_s;
                    o_rdata             <= ram_r[lat_widx_r];
                    o_rvalid            <= 1'b1;
                end
                default: begin
                    o_rvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    logic [15:0] hit_cnt_r;
    logic [15:0] miss_cnt_r;

    // Saturating load-hit / load-miss statistics.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hit_cnt_r  <= 16'h0000;
            miss_cnt_r <= 16'h0000;
        end else begin
            if (hit_accept_s && (hit_cnt_r != 16'hFFFF)) begin
                hit_cnt_r <= hit_cnt_r + 16'h0001;
            end
            if (miss_detect_s && (miss_cnt_r != 16'hFFFF)) begin
                miss_cnt_r <= miss_cnt_r + 16'h0001;
            end
        end
    end

    assign o_hit_cnt  = hit_cnt_r;
    assign o_miss_cnt = miss_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        Clk;
    logic        Rst;
    logic        i_req_valid;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [3:0]  i_req_be;
    logic [31:0] i_req_wdata;
    logic [31:0] o_rdata;
    logic        o_rvalid;
    logic        o_miss;
    logic        o_busy;
`ifdef DMEM_STATS_EN
    logic [15:0] o_hit_cnt;
    logic [15:0] o_miss_cnt;
`endif

    int nv;
    int nerr;

    dmem_responder #(
        .MEM_DEPTH(1024),
        .LINES    (16),
        .MISS_LAT (4)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_req_valid(i_req_valid),
        .i_req_we   (i_req_we),
        .i_req_addr (i_req_addr),
        .i_req_be   (i_req_be),
        .i_req_wdata(i_req_wdata),
        .o_rdata    (o_rdata),
        .o_rvalid   (o_rvalid),
        .o_miss     (o_miss),
        .o_busy     (o_busy)
`ifdef DMEM_STATS_EN
        ,
        .o_hit_cnt  (o_hit_cnt),
        .o_miss_cnt (o_miss_cnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Store for one cycle; reports o_miss seen during the store cycle and
    // o_rvalid after its edge.
    task automatic do_store(input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data,
                            output logic miss_seen, output logic rv_seen);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = addr;
        i_req_be    = be;
        i_req_wdata = data;
        #1;
        miss_seen = o_miss;
        tick();
        rv_seen = o_rvalid;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
    endtask

    // Issue a load and hold it until o_rvalid; counts stall cycles.
    task automatic do_load(input logic [31:0] addr, output int stall,
                           output logic [31:0] data, output logic tmo);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = addr;
        stall = 0;
        data  = 32'h0;
        tmo   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (o_miss) stall++;
            tick();
            if (o_rvalid) begin
                data = o_rdata;
                tmo  = 1'b0;
                break;
            end
        end
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        nv++; if (o_rvalid !== 1'b0) begin nerr++; $display("FAIL reset_rvalid got %b want 0", o_rvalid); end
        nv++; if (o_miss !== 1'b0) begin nerr++; $display("FAIL reset_miss got %b want 0", o_miss); end
        nv++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", o_busy); end
        nv++; if (o_rdata !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h want 00000000", o_rdata); end
        Rst = 1'b0;
    endtask

    task automatic preload();
        logic m;
        logic r;
        do_store(32'h40,  4'hF, 32'h1111_1111, m, r);
        do_store(32'h44,  4'hF, 32'h6666_6666, m, r);
        do_store(32'h80,  4'hF, 32'h4444_4444, m, r);
        do_store(32'hC0,  4'hF, 32'h5555_5555, m, r);
        do_store(32'h440, 4'hF, 32'h3333_3333, m, r);
        tick();
    endtask

    task automatic test_miss_fill();
        int st;
        logic [31:0] d;
        logic to;
        do_load(32'h40, st, d, to);
        nv++; if (to || st != 5) begin nerr++; $display("FAIL miss_stall got %0d (timeout %b) want 5", st, to); end
        nv++; if (d !== 32'h1111_1111) begin nerr++; $display("FAIL miss_data got %h want 11111111", d); end
        tick();
        nv++; if (o_rvalid !== 1'b0) begin nerr++; $display("FAIL rvalid_pulse got %b want 0", o_rvalid); end
        do_load(32'h40, st, d, to);
        nv++; if (to || st != 0) begin nerr++; $display("FAIL hit_stall got %0d (timeout %b) want 0", st, to); end
        nv++; if (d !== 32'h1111_1111) begin nerr++; $display("FAIL hit_data got %h want 11111111", d); end
        tick();
    endtask

    task automatic test_store();
        int st;
        logic [31:0] d;
        logic to;
        logic m;
        logic r;
        do_store(32'h40, 4'hF, 32'hDEAD_BEEF, m, r);
        nv++; if (m !== 1'b0 || r !== 1'b0) begin nerr++; $display("FAIL store_nostall miss %b rvalid %b want 0 0", m, r); end
        do_load(32'h40, st, d, to);
        nv++; if (to || st != 0 || d !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL store_full got %h stall %0d want deadbeef stall 0", d, st); end
        do_store(32'h40, 4'b0010, 32'h0000_AA00, m, r);
        do_load(32'h40, st, d, to);
        nv++; if (to || d !== 32'hDEAD_AAEF) begin nerr++; $display("FAIL store_byte1 got %h want deadaaef", d); end
        do_store(32'h40, 4'b0000, 32'h0000_0000, m, r);
        do_load(32'h40, st, d, to);
        nv++; if (to || d !== 32'hDEAD_AAEF) begin nerr++; $display("FAIL store_be0 got %h want deadaaef", d); end
        tick();
    endtask

    task automatic test_conflict();
        int st;
        logic [31:0] d;
        logic to;
        // 0x1040 aliases to word 16 (same tag as 0x40) with a 1024-word RAM
        do_load(32'h1040, st, d, to);
        nv++; if (to || st != 0 || d !== 32'hDEAD_AAEF) begin nerr++; $display("FAIL alias got %h stall %0d want deadaaef stall 0", d, st); end
        do_load(32'h440, st, d, to);
        nv++; if (to || st != 5 || d !== 32'h3333_3333) begin nerr++; $display("FAIL conflict got %h stall %0d want 33333333 stall 5", d, st); end
        do_load(32'h40, st, d, to);
        nv++; if (to || st != 5 || d !== 32'hDEAD_AAEF) begin nerr++; $display("FAIL evicted got %h stall %0d want deadaaef stall 5", d, st); end
        tick();
    endtask

    task automatic test_reset_mid_miss();
        int st;
        logic [31:0] d;
        logic to;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h44;
        #1;
        nv++; if (o_miss !== 1'b1) begin nerr++; $display("FAIL detect_miss got %b want 1", o_miss); end
        tick();
        tick();
        tick();
        nv++; if (o_busy !== 1'b1 || o_miss !== 1'b1) begin nerr++; $display("FAIL miss3 busy %b miss %b want 1 1", o_busy, o_miss); end
        Rst = 1'b1;
        i_req_valid = 1'b0;
        tick();
        nv++; if (o_busy !== 1'b0 || o_miss !== 1'b0 || o_rvalid !== 1'b0) begin nerr++; $display("FAIL abort busy %b miss %b rvalid %b want 0 0 0", o_busy, o_miss, o_rvalid); end
        Rst = 1'b0;
        tick();
        nv++; if (o_rvalid !== 1'b0) begin nerr++; $display("FAIL abort_rvalid got %b want 0", o_rvalid); end
        do_load(32'h44, st, d, to);
        nv++; if (to || st != 5 || d !== 32'h6666_6666) begin nerr++; $display("FAIL after_abort got %h stall %0d want 66666666 stall 5", d, st); end
        tick();
    endtask

    task automatic test_addr_change();
        int st;
        logic [31:0] d;
        logic to;
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h80;
        st = 0;
        d  = 32'h0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (o_miss) st++;
            tick();
            i_req_addr = 32'hC0;
            if (o_rvalid) begin
                d  = o_rdata;
                to = 1'b0;
                break;
            end
        end
        i_req_valid = 1'b0;
        nv++; if (to || st != 5 || d !== 32'h4444_4444) begin nerr++; $display("FAIL latched got %h stall %0d want 44444444 stall 5", d, st); end
        tick();
        do_load(32'h80, st, d, to);
        nv++; if (to || st != 0 || d !== 32'h4444_4444) begin nerr++; $display("FAIL tag80 got %h stall %0d want 44444444 stall 0", d, st); end
        do_load(32'hC0, st, d, to);
        nv++; if (to || st != 5 || d !== 32'h5555_5555) begin nerr++; $display("FAIL tagC0 got %h stall %0d want 55555555 stall 5", d, st); end
        tick();
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        int st;
        logic [31:0] d;
        logic to;
        logic m;
        logic r;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        nv++; if (o_hit_cnt !== 16'd0 || o_miss_cnt !== 16'd0) begin nerr++; $display("FAIL stats_reset hit %0d miss %0d want 0 0", o_hit_cnt, o_miss_cnt); end
        do_load(32'h40, st, d, to);
        do_load(32'h40, st, d, to);
        do_load(32'h44, st, d, to);
        do_load(32'h44, st, d, to);
        do_load(32'h80, st, d, to);
        do_store(32'h100, 4'hF, 32'h1234_5678, m, r);
        tick();
        nv++; if (o_hit_cnt !== 16'd2) begin nerr++; $display("FAIL stats_hit got %0d want 2", o_hit_cnt); end
        nv++; if (o_miss_cnt !== 16'd3) begin nerr++; $display("FAIL stats_miss got %0d want 3", o_miss_cnt); end
    endtask
`endif

    initial begin
        nv          = 0;
        nerr        = 0;
        Rst         = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h0;
        i_req_be    = 4'h0;
        i_req_wdata = 32'h0;
        tick();
        test_reset();
        preload();
        test_miss_fill();
        test_store();
        test_conflict();
        test_reset_mid_miss();
        test_addr_change();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
